// File: rtl/reg_port_sequencer.sv
// reg_port_sequencer
// Serialises operand reads and writebacks onto a shared two-port register
// file whose read data is registered inside the file. Reads walk
// IDLE -> READ -> CAPT -> RESP; writebacks walk IDLE -> WRITE.
//
// Build option: define REG_SEQ_ZERO_REG_EN to make register 0 read as zero
// and to drop writebacks that target it.
module reg_port_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req_valid,
  output logic       rd_req_ready,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [4:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic [4:0] rf_rA,
  output logic [4:0] rf_rB,
  output logic [7:0] rf_data_in,
  output logic       rf_we,
  input  logic [7:0] rf_outA,
  input  logic [7:0] rf_outB
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] CAPT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [4:0] wb_addr_q;
  logic [7:0] wb_data_q;
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;
  logic       wb_to_zero;
  logic [7:0] cap_a;
  logic [7:0] cap_b;

`ifdef REG_SEQ_ZERO_REG_EN
  // Register 0 is hard-wired: its writebacks are swallowed, its reads are zero.
  assign wb_to_zero = (wb_addr == 5'd0);
  assign cap_a      = (rs1_q == 5'd0) ? 8'h00 : rf_outA;
  assign cap_b      = (rs2_q == 5'd0) ? 8'h00 : rf_outB;
`else
  assign wb_to_zero = 1'b0;
  assign cap_a      = rf_outA;
  assign cap_b      = rf_outB;
`endif

  // Next-state selection; writeback has priority over a read in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (wb_valid)          next_state = wb_to_zero ? IDLE : WRITE;
        else if (rd_req_valid) next_state = READ;
      end
      WRITE:   next_state = IDLE;
      READ:    next_state = CAPT;
      CAPT:    next_state = RESP;
      RESP:    if (op_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Request latches, loaded only on the accept edge in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the latches are reset so a stale address can never reach the file after reset.
    if (reset) begin
      wb_addr_q <= 5'd0;
      wb_data_q <= 8'h00;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
    end else if (state == IDLE) begin
      if (wb_valid) begin
        wb_addr_q <= wb_addr;
        wb_data_q <= wb_data;
      end else if (rd_req_valid) begin
        rs1_q <= rs1;
        rs2_q <= rs2;
      end
    end
  end

  // Operand capture at the end of CAPT; held stable through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a <= 8'h00;
      op_b <= 8'h00;
    end else if (state == CAPT) begin
      op_a <= cap_a;
      op_b <= cap_b;
    end
  end

  // Handshake and register-file drive, decoded from the current state.
  always_comb begin
    wb_ready     = 1'b0;
    rd_req_ready = 1'b0;
    op_valid     = 1'b0;
    rf_we        = 1'b0;
    rf_rA        = 5'd0;
    rf_rB        = 5'd0;
    rf_data_in   = 8'h00;
    case (state)
      IDLE: begin
        wb_ready     = 1'b1;
        rd_req_ready = !wb_valid;
      end
      WRITE: begin
        rf_we      = 1'b1;
        rf_rA      = wb_addr_q;
        rf_data_in = wb_data_q;
      end
      READ, CAPT: begin
        rf_rA = rs1_q;
        rf_rB = rs2_q;
      end
      RESP:    op_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_port_sequencer.sv
// tb_reg_port_sequencer
// Directed bench for reg_port_sequencer with a behavioural register file
// (registered read data, one edge after the addresses). Inputs change and
// outputs are sampled on the falling edge.
module tb_reg_port_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_req_valid = 1'b0;
  logic       rd_req_ready;
  logic [4:0] rs1 = 5'd0;
  logic [4:0] rs2 = 5'd0;
  logic       op_valid;
  logic       op_ready = 1'b0;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       wb_valid = 1'b0;
  logic       wb_ready;
  logic [4:0] wb_addr = 5'd0;
  logic [7:0] wb_data = 8'h00;
  logic [4:0] rf_rA;
  logic [4:0] rf_rB;
  logic [7:0] rf_data_in;
  logic       rf_we;
  logic [7:0] rf_outA = 8'h00;
  logic [7:0] rf_outB = 8'h00;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  logic [7:0] rf_mem [32];

  reg_port_sequencer dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rs1(rs1), .rs2(rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_rA(rf_rA), .rf_rB(rf_rB), .rf_data_in(rf_data_in), .rf_we(rf_we),
    .rf_outA(rf_outA), .rf_outB(rf_outB)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous write, registered read data.
  initial for (int i = 0; i < 32; i++) rf_mem[i] = 8'h00;
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_rA] <= rf_data_in;
    rf_outA <= rf_mem[rf_rA];
    rf_outB <= rf_mem[rf_rB];
  end

  // Count write-enable cycles.
  always @(negedge clk) if (rf_we === 1'b1) we_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept a writeback: drive, wait (bounded) for wb_ready, let one edge pass.
  task automatic do_write(input logic [4:0] a, input logic [7:0] d, output logic ok);
    ok = 1'b0;
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (wb_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    @(negedge clk);
  endtask

  // Issue a read and wait (bounded) until op_valid; leaves op_ready low.
  task automatic start_read(input logic [4:0] a, input logic [4:0] b, output logic ok);
    logic acc;
    acc = 1'b0;
    ok  = 1'b0;
    rd_req_valid = 1'b1; rs1 = a; rs2 = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (rd_req_ready === 1'b1) acc = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    rd_req_valid = 1'b0;
    for (int i = 0; i < 20 && acc && !ok; i++) begin
      if (op_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic finish_read();
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({op_valid, op_a, op_b, rf_we, rf_rA, rf_rB, rf_data_in} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h we=%b rA=%0d rB=%0d din=%h, need all zero",
               op_valid, op_a, op_b, rf_we, rf_rA, rf_rB, rf_data_in);
    end
  endtask

  // First read right out of reset: exact cycle-by-cycle latency.
  task automatic test_first_read();
    reset = 1'b0;
    rd_req_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd4;
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      failures++; $display("FAIL first_ready: got %b, need 1", rd_req_ready);
    end
    @(negedge clk);                 // accept edge passed -> READ
    rd_req_valid = 1'b0;
    checks++;
    if ({rd_req_ready, op_valid, rf_we, rf_rA, rf_rB} !== {3'b000, 5'd3, 5'd4}) begin
      failures++;
      $display("FAIL read_drive: got rdy=%b v=%b we=%b rA=%0d rB=%0d, need 0 0 0 3 4",
               rd_req_ready, op_valid, rf_we, rf_rA, rf_rB);
    end
    @(negedge clk);                 // CAPT
    checks++;
    if (op_valid !== 1'b0) begin
      failures++; $display("FAIL early_valid: got %b, need 0", op_valid);
    end
    @(negedge clk);                 // RESP, accept edge counted as the first
    checks++;
    if ({op_valid, op_a, op_b} !== {1'b1, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL first_resp: got v=%b a=%h b=%h, need 1 00 00", op_valid, op_a, op_b);
    end
    finish_read();
    checks++;
    if ({op_valid, rd_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL back_to_idle: got v=%b rdy=%b, need 0 1", op_valid, rd_req_ready);
    end
  endtask

  task automatic test_write_read();
    logic ok;
    we_cnt = 0;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 8'hA5;
    @(negedge clk);                 // WRITE
    wb_valid = 1'b0;
    checks++;
    if ({rf_we, rf_rA, rf_rB, rf_data_in, wb_ready, rd_req_ready} !== {1'b1, 5'd5, 5'd0, 8'hA5, 2'b00}) begin
      failures++;
      $display("FAIL write_drive: got we=%b rA=%0d rB=%0d din=%h wrdy=%b rrdy=%b, need 1 5 0 a5 0 0",
               rf_we, rf_rA, rf_rB, rf_data_in, wb_ready, rd_req_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_mem[5] !== 8'hA5) begin
      failures++; $display("FAIL write_landed: got %h, need a5", rf_mem[5]);
    end
    start_read(5'd5, 5'd5, ok);
    checks++;
    if ({ok, op_a, op_b} !== {1'b1, 8'hA5, 8'hA5}) begin
      failures++; $display("FAIL read_after_write: got ok=%b a=%h b=%h, need 1 a5 a5", ok, op_a, op_b);
    end
    finish_read();
    checks++;
    if (we_cnt !== 1) begin
      failures++; $display("FAIL we_pulse: got %0d cycles, need 1", we_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    // Same-cycle writeback and read: the writeback goes first.
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 8'h3C;
    rd_req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd0;
    #1;
    checks++;
    if ({wb_ready, rd_req_ready} !== 2'b10) begin
      failures++; $display("FAIL collide_ready: got wrdy=%b rrdy=%b, need 1 0", wb_ready, rd_req_ready);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    checks++;
    if ({rf_we, rf_rA} !== {1'b1, 5'd7}) begin
      failures++; $display("FAIL collide_write: got we=%b rA=%0d, need 1 7", rf_we, rf_rA);
    end
    start_read(5'd7, 5'd0, ok);
    checks++;
    if ({ok, op_a, op_b} !== {1'b1, 8'h3C, 8'h00}) begin
      failures++; $display("FAIL collide_read: got ok=%b a=%h b=%h, need 1 3c 00", ok, op_a, op_b);
    end
    finish_read();
  endtask

  task automatic test_backpressure();
    logic ok;
    logic bad;
    do_write(5'd9, 8'h5A, ok);
    start_read(5'd9, 5'd5, ok);
    checks++;
    if ({ok, op_a, op_b} !== {1'b1, 8'h5A, 8'hA5}) begin
      failures++; $display("FAIL bp_first: got ok=%b a=%h b=%h, need 1 5a a5", ok, op_a, op_b);
    end
    // A writeback arriving during RESP must wait.
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 8'h77;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({op_valid, op_a, op_b, wb_ready, rf_we} !== {1'b1, 8'h5A, 8'hA5, 2'b00}) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL bp_hold: got v=%b a=%h b=%h wrdy=%b, need 1 5a a5 0 for 5 cycles",
                           op_valid, op_a, op_b, wb_ready);
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    checks++;
    if ({op_valid, wb_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_release: got v=%b wrdy=%b, need 0 1", op_valid, wb_ready);
    end
    @(negedge clk);                 // waiting writeback now in WRITE
    wb_valid = 1'b0;
    @(negedge clk);
    start_read(5'd10, 5'd9, ok);
    checks++;
    if ({ok, op_a, op_b} !== {1'b1, 8'h77, 8'h5A}) begin
      failures++; $display("FAIL bp_no_loss: got ok=%b a=%h b=%h, need 1 77 5a", ok, op_a, op_b);
    end
    finish_read();
  endtask

  task automatic test_reset_mid_op();
    logic ok;
    logic seen;
    do_write(5'd12, 8'hC3, ok);
    rd_req_valid = 1'b1; rs1 = 5'd12; rs2 = 5'd12;
    @(negedge clk);                 // READ
    rd_req_valid = 1'b0;
    @(negedge clk);                 // CAPT
    reset = 1'b1;
    #1;
    checks++;
    if ({op_valid, op_a, op_b, rf_we, rf_rA, rf_rB, rf_data_in} !== 36'd0) begin
      failures++;
      $display("FAIL capt_reset: got v=%b a=%h b=%h we=%b rA=%0d rB=%0d din=%h, need all zero",
               op_valid, op_a, op_b, rf_we, rf_rA, rf_rB, rf_data_in);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (op_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL ghost_resp: got op_valid high after reset, need 0");
    end
    // Reset during WRITE: the write must not land.
    wb_valid = 1'b1; wb_addr = 5'd13; wb_data = 8'hEE;
    @(negedge clk);
    wb_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_read(5'd12, 5'd13, ok);
    checks++;
    if ({ok, op_a, op_b} !== {1'b1, 8'hC3, 8'h00}) begin
      failures++; $display("FAIL post_reset_read: got ok=%b a=%h b=%h, need 1 c3 00", ok, op_a, op_b);
    end
    finish_read();
  endtask

  task automatic test_zero_reg();
    logic ok;
    logic [7:0] exp_a;
    int exp_we;
`ifdef REG_SEQ_ZERO_REG_EN
    exp_a = 8'h00; exp_we = 0;
`else
    exp_a = 8'hFF; exp_we = 1;
`endif
    we_cnt = 0;
    do_write(5'd0, 8'hFF, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL zero_accept: got %b, need 1", ok);
    end
    start_read(5'd0, 5'd5, ok);
    checks++;
    if ({ok, op_a, op_b} !== {1'b1, exp_a, 8'hA5}) begin
      failures++; $display("FAIL zero_read: got ok=%b a=%h b=%h, need 1 %h a5", ok, op_a, op_b, exp_a);
    end
    finish_read();
    checks++;
    if (we_cnt !== exp_we) begin
      failures++; $display("FAIL zero_we: got %0d cycles, need %0d", we_cnt, exp_we);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_zero_reg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
